// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges UART byte stores from both issue lanes into one
// in-order queue and drains it to the UART core one frame time apart.
// Lane 1 is queued ahead of lane 2 when both store in the same cycle.
module uart_tx_arbiter #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned GAP_CYCLES = 8680
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr1_i,
  input  logic [7:0]       data1_i,
  input  logic             wr2_i,
  input  logic [7:0]       data2_i,
  output logic             uart_wr_o,
  output logic [7:0]       uart_dat_o,
  output logic             stall_o,
  output logic             overflow_o,
  output logic [PTR_W:0]   count_o,
  output logic             idle_o
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_uart_wr;
  logic [7:0]       r_uart_dat;
  state_t           r_state;
  logic [GAP_W-1:0] r_gap;

  state_t           w_state_next;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_pop;
  logic [PTR_W:0]   w_free;
  logic             w_acc1;
  logic             w_acc2;
  logic             w_drop;
  logic [1:0]       w_push_n;
  logic [PTR_W-1:0] w_wptr2;

  // Admission: free space is taken from the registered count, so a pop on
  // this same edge never makes room for a push arriving alongside it.
  always_comb begin
    w_free   = (PTR_W+1)'(DEPTH) - r_count;
    w_acc1   = wr1_i && (w_free != '0);
    if (wr1_i) begin
      w_acc2 = wr2_i && (w_free >= (PTR_W+1)'(2));
    end else begin
      w_acc2 = wr2_i && (w_free != '0);
    end
    w_drop   = (wr1_i && !w_acc1) || (wr2_i && !w_acc2);
    w_push_n = {1'b0, w_acc1} + {1'b0, w_acc2};
    w_wptr2  = w_acc1 ? (r_tail + PTR_W'(1)) : r_tail;
  end

  // Queue storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (w_acc1) begin
      r_mem[r_tail] <= data1_i;
    end
    if (w_acc2) begin
      r_mem[w_wptr2] <= data2_i;
    end
  end

  // Pointers, exact occupancy count and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_head  <= r_head + PTR_W'(w_pop);
      r_count <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Drain FSM state register and frame-gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
    end
  end

  // Drain FSM next state: pop one byte when idle and non-empty, then sit
  // out the rest of the frame time counting down the gap.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_gap_next   = GAP_W'(GAP_CYCLES - 1);
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_gap_next = r_gap - GAP_W'(1);
        if (r_gap == GAP_W'(1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered write strobe and data to the UART core; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_uart_wr  <= 1'b0;
      r_uart_dat <= '0;
    end else begin
      r_uart_wr <= w_pop;
      if (w_pop) begin
        r_uart_dat <= r_mem[r_head];
      end
    end
  end

  assign uart_wr_o  = r_uart_wr;
  assign uart_dat_o = r_uart_dat;
  assign overflow_o = r_overflow;
  assign count_o    = r_count;
  assign stall_o    = (r_count >= (PTR_W+1)'(DEPTH - 2));
  assign idle_o     = (r_count == '0) && (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with DEPTH=4, GAP_CYCLES=4.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr1_i;
  logic [7:0] data1_i;
  logic       wr2_i;
  logic [7:0] data2_i;
  logic       uart_wr_o;
  logic [7:0] uart_dat_o;
  logic       stall_o;
  logic       overflow_o;
  logic [2:0] count_o;
  logic       idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got [8];
  int         n_got;

  uart_tx_arbiter #(
    .DEPTH(4),
    .PTR_W(2),
    .GAP_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr1_i(wr1_i),
    .data1_i(data1_i),
    .wr2_i(wr2_i),
    .data2_i(data2_i),
    .uart_wr_o(uart_wr_o),
    .uart_dat_o(uart_dat_o),
    .stall_o(stall_o),
    .overflow_o(overflow_o),
    .count_o(count_o),
    .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w1, input logic [7:0] d1, input logic w2, input logic [7:0] d2);
    wr1_i   = w1;
    data1_i = d1;
    wr2_i   = w2;
    data2_i = d2;
    tick();
    wr1_i   = 1'b0;
    wr2_i   = 1'b0;
  endtask

  // Collect emitted bytes until the block reports idle (bounded).
  task automatic drain();
    n_got = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (uart_wr_o === 1'b1) begin
        if (n_got < 8) got[n_got] = uart_dat_o;
        n_got++;
      end
      if (idle_o === 1'b1) break;
    end
    check("drain_idle", idle_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int saw_wr;
    rst = 1'b1; wr1_i = 1'b0; wr2_i = 1'b0; data1_i = '0; data2_i = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset then idle
    for (int i = 0; i < 10; i++) tick();
    check("rst_wr", uart_wr_o, 0);
    check("rst_count", count_o, 0);
    check("rst_idle", idle_o, 1);
    check("rst_stall", stall_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_dat", uart_dat_o, 8'h00);

    // 2. single byte: pulse in the cycle after edge N+1
    push(1'b1, 8'h41, 1'b0, 8'h00);
    check("s2_cnt_N", count_o, 1);
    check("s2_wr_N", uart_wr_o, 0);
    check("s2_idle_N", idle_o, 0);
    tick();
    check("s2_wr_N1", uart_wr_o, 1);
    check("s2_dat_N1", uart_dat_o, 8'h41);
    check("s2_cnt_N1", count_o, 0);
    tick();
    check("s2_wr_N2", uart_wr_o, 0);
    check("s2_dat_hold", uart_dat_o, 8'h41);
    tick();
    check("s2_idle_N3", idle_o, 0);
    tick();
    check("s2_idle_N4", idle_o, 1);

    // 3. dual issue: 48 then 49, pulses four cycles apart
    push(1'b1, 8'h48, 1'b1, 8'h49);
    check("s3_cnt", count_o, 2);
    check("s3_stall", stall_o, 1);
    tick();
    check("s3_wr1", uart_wr_o, 1);
    check("s3_dat1", uart_dat_o, 8'h48);
    check("s3_stall_off", stall_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_gap_wr", uart_wr_o, 0);
    end
    tick();
    check("s3_wr2", uart_wr_o, 1);
    check("s3_dat2", uart_dat_o, 8'h49);
    for (int i = 0; i < 4; i++) tick();
    check("s3_idle", idle_o, 1);

    // 4. back-to-back pairs; third pair meets free=1 (3 queued after the
    //    pop), so 05 is admitted and 06 dropped
    push(1'b1, 8'h01, 1'b1, 8'h02);
    check("s4_cnt_a", count_o, 2);
    push(1'b1, 8'h03, 1'b1, 8'h04);
    check("s4_wr_a1", uart_wr_o, 1);
    check("s4_dat_a1", uart_dat_o, 8'h01);
    check("s4_cnt_a1", count_o, 3);
    check("s4_ovf_a1", overflow_o, 0);
    push(1'b1, 8'h05, 1'b1, 8'h06);
    check("s4_cnt_a2", count_o, 4);
    check("s4_ovf_a2", overflow_o, 1);
    check("s4_stall", stall_o, 1);
    drain();
    check("s4_n", n_got, 4);
    check("s4_b0", got[0], 8'h02);
    check("s4_b1", got[1], 8'h03);
    check("s4_b2", got[2], 8'h04);
    check("s4_b3", got[3], 8'h05);
    check("s4_ovf_sticky", overflow_o, 1);

    // 5. partial accept with count=3 during WAIT (no pop that edge)
    rst = 1'b1; tick(); rst = 1'b0;
    check("s5_ovf_clr", overflow_o, 0);
    push(1'b1, 8'h11, 1'b1, 8'h22);
    push(1'b1, 8'h33, 1'b0, 8'h00);
    check("s5_wr_11", uart_wr_o, 1);
    check("s5_dat_11", uart_dat_o, 8'h11);
    check("s5_cnt_b1", count_o, 2);
    push(1'b1, 8'h44, 1'b0, 8'h00);
    check("s5_cnt_b2", count_o, 3);
    check("s5_ovf_b2", overflow_o, 0);
    push(1'b1, 8'hAA, 1'b1, 8'hBB);
    check("s5_cnt_b3", count_o, 4);
    check("s5_ovf_b3", overflow_o, 1);
    check("s5_wr_b3", uart_wr_o, 0);
    drain();
    check("s5_n", n_got, 4);
    check("s5_b0", got[0], 8'h22);
    check("s5_b1", got[1], 8'h33);
    check("s5_b2", got[2], 8'h44);
    check("s5_b3", got[3], 8'hAA);

    // 6. reset mid-WAIT with two bytes queued
    push(1'b1, 8'h01, 1'b1, 8'h02);
    push(1'b1, 8'h03, 1'b0, 8'h00);
    check("s6_wr_pre", uart_wr_o, 1);
    check("s6_cnt_pre", count_o, 2);
    check("s6_ovf_pre", overflow_o, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("s6_cnt_rst", count_o, 0);
    check("s6_wr_rst", uart_wr_o, 0);
    check("s6_ovf_rst", overflow_o, 0);
    check("s6_idle_rst", idle_o, 1);
    check("s6_dat_rst", uart_dat_o, 8'h00);
    saw_wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (uart_wr_o !== 1'b0) saw_wr++;
    end
    check("s6_no_pulse", saw_wr, 0);
    push(1'b1, 8'h5A, 1'b0, 8'h00);
    check("s6_cnt_new", count_o, 1);
    check("s6_wr_new0", uart_wr_o, 0);
    tick();
    check("s6_wr_new1", uart_wr_o, 1);
    check("s6_dat_new1", uart_dat_o, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
